eth_rt_rx_source: RTL

//  Switch-side source feeding the GMII receive inputs of the real-time Ethernet interface.

---
 rtl/eth_rt_rx_source_pkg.sv | 15 +
 rtl/eth_rt_rx_source_if.sv | 24 ++
 rtl/eth_rt_ipg_timer.sv | 34 +++
 rtl/eth_rt_rx_source.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/eth_rt_rx_source_pkg.sv
// Shared constants for the real-time Ethernet receive-side source: line bytes and FSM encodings.
package eth_rt_rx_source_pkg;

  localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;

  typedef logic [2:0] src_state_t;

  localparam src_state_t ST_SRC_IDLE  = 3'd0;
  localparam src_state_t ST_SRC_PRE   = 3'd1;
  localparam src_state_t ST_SRC_SFD   = 3'd2;
  localparam src_state_t ST_SRC_DATA  = 3'd3;
  localparam src_state_t ST_SRC_ABORT = 3'd4;

endpackage

// File: rtl/eth_rt_rx_source_if.sv
// Source-buffer pop interface plus GMII-style receive byte stream of one switch port.
interface eth_rt_rx_source_if;
  logic       src_avail;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_last;
  logic [3:0] src_info;
  logic       src_pop;
  logic       PortReady;
  logic       RxValid;
  logic [7:0] RxD;
  logic       RxErr;
  logic [3:0] PacketInfo;

  // master: the frame source; slave: buffer plus consumer side
  modport master (
    input  src_avail, src_valid, src_data, src_last, src_info, PortReady,
    output src_pop, RxValid, RxD, RxErr, PacketInfo
  );
  modport slave (
    output src_avail, src_valid, src_data, src_last, src_info, PortReady,
    input  src_pop, RxValid, RxD, RxErr, PacketInfo
  );
endinterface

// File: rtl/eth_rt_ipg_timer.sv
// Inter-packet gap down-counter: loads on frame end, counts down while enabled, saturates at 0.
module eth_rt_ipg_timer #(
  parameter int unsigned Width   = 8,
  parameter int unsigned LoadVal = 11
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic run_i,
  output logic done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = Width'(LoadVal);
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/eth_rt_rx_source.sv
// Pops stored frames from the upstream buffer and emits preamble, SFD and payload,
// each byte two clocks after PortReady, with IPG enforcement and underrun reporting.
module eth_rt_rx_source
  import eth_rt_rx_source_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IPG_BYTES    = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  eth_rt_rx_source_if.master        bus,
  input  logic                      clearErrors,
  output logic                      underrun,
  output logic [7:0]                numFrames
);

  src_state_t state_q, state_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic       rdy_q;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rxd_q, rxd_d;
  logic       rx_err_q, rx_err_d;
  logic [3:0] info_q, info_d;
  logic       underrun_q, underrun_d;
  logic [7:0] frames_q, frames_d;
  logic       src_pop_d;
  logic       issue;
  logic       ipg_load;
  logic       ipg_done;

  assign issue = rdy_q & (state_q != ST_SRC_IDLE);

  // The clock spent in PRE before the first 0x55 is issued counts as one gap clock.
  eth_rt_ipg_timer #(
    .Width   (8),
    .LoadVal (IPG_BYTES - 1)
  ) u_ipg_timer (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (ipg_load),
    .run_i   (state_q == ST_SRC_IDLE),
    .done_o  (ipg_done)
  );

  always_comb begin
    state_d    = state_q;
    tx_cnt_d   = tx_cnt_q;
    rx_valid_d = 1'b0;
    rxd_d      = 8'h00;
    rx_err_d   = 1'b0;
    info_d     = info_q;
    frames_d   = frames_q;
    underrun_d = underrun_q & ~clearErrors;
    src_pop_d  = 1'b0;
    ipg_load   = 1'b0;

    case (state_q)
      ST_SRC_IDLE: begin
        if (bus.src_avail && bus.src_valid && ipg_done) begin
          state_d  = ST_SRC_PRE;
          tx_cnt_d = 4'd0;
        end
      end
      ST_SRC_PRE: begin
        if (issue) begin
          rx_valid_d = 1'b1;
          rxd_d      = ETH_PREAMBLE_BYTE;
          tx_cnt_d   = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'(PREAMBLE_LEN - 1)) begin
            state_d = ST_SRC_SFD;
          end
        end
      end
      ST_SRC_SFD: begin
        if (issue) begin
          rx_valid_d = 1'b1;
          rxd_d      = ETH_SFD_BYTE;
          info_d     = bus.src_info;
          state_d    = ST_SRC_DATA;
        end
      end
      ST_SRC_DATA: begin
        if (issue) begin
          rx_valid_d = 1'b1;
          if (bus.src_valid) begin
            rxd_d     = bus.src_data;
            src_pop_d = 1'b1;
            if (bus.src_last) begin
              frames_d = frames_q + 8'd1;
              ipg_load = 1'b1;
              state_d  = ST_SRC_IDLE;
            end
          end else begin
            // Source ran dry mid-frame: flag the byte and discard the rest of the frame.
            rx_err_d   = 1'b1;
            underrun_d = 1'b1;
            state_d    = ST_SRC_ABORT;
          end
        end
      end
      ST_SRC_ABORT: begin
        if (issue && bus.src_valid) begin
          src_pop_d = 1'b1;
          if (bus.src_last) begin
            ipg_load = 1'b1;
            state_d  = ST_SRC_IDLE;
          end
        end
      end
      default: state_d = ST_SRC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_SRC_IDLE;
      tx_cnt_q   <= 4'd0;
      rdy_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rxd_q      <= 8'h00;
      rx_err_q   <= 1'b0;
      info_q     <= 4'h0;
      underrun_q <= 1'b0;
      frames_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      tx_cnt_q   <= tx_cnt_d;
      rdy_q      <= bus.PortReady;
      rx_valid_q <= rx_valid_d;
      rxd_q      <= rxd_d;
      rx_err_q   <= rx_err_d;
      info_q     <= info_d;
      underrun_q <= underrun_d;
      frames_q   <= frames_d;
    end
  end

  assign bus.src_pop    = src_pop_d;
  assign bus.RxValid    = rx_valid_q;
  assign bus.RxD        = rxd_q;
  assign bus.RxErr      = rx_err_q;
  assign bus.PacketInfo = info_q;
  assign underrun       = underrun_q;
  assign numFrames      = frames_q;

endmodule
